// File: rtl/axi_master_read.sv
// AXI4 read master: issues a single INCR burst per rd_start and streams the beats into a read FIFO.
// Optional build macro RD_ERR_CHECK_EN adds the sticky rd_err output and per-beat response checking.
module axi_master_read (
   input  logic        axi_clk,
   input  logic        axi_rst_n,
   output logic [3:0]  m_axi_ar_id,
   output logic [31:0] m_axi_ar_addr,
   output logic [7:0]  m_axi_ar_len,
   output logic [2:0]  m_axi_ar_size,
   output logic [1:0]  m_axi_ar_burst,
   output logic        m_axi_ar_lock,
   output logic [3:0]  m_axi_ar_cache,
   output logic [2:0]  m_axi_ar_prot,
   output logic [3:0]  m_axi_ar_qos,
   output logic        m_axi_ar_valid,
   input  logic        m_axi_ar_ready,
   input  logic [3:0]  m_axi_r_id,
   input  logic [63:0] m_axi_r_data,
   input  logic [1:0]  m_axi_r_resp,
   input  logic        m_axi_r_last,
   input  logic        m_axi_r_valid,
   output logic        m_axi_r_ready,
   input  logic        rd_start,
   input  logic [31:0] rd_adrs,
   input  logic [9:0]  rd_len,
   output logic        rd_ready,
   output logic        rd_fifo_we,
   output logic [63:0] rd_fifo_data,
   output logic        rd_done
`ifdef RD_ERR_CHECK_EN
   ,
   output logic        rd_err
`endif
);

   localparam logic [3:0] AR_ID = 4'b1111;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RA_WAIT  = 3'd1,
      RA_START = 3'd2,
      RA_HS    = 3'd3,
      RD_PROC  = 3'd4,
      RD_DONE  = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] ar_addr_q, ar_addr_nxt;
   logic        ar_valid_q, ar_valid_nxt;
   logic [7:0]  cnt_q, cnt_nxt;
   logic [9:0]  len_m1;
   logic        r_hs;
   logic        unused_ok;

   assign len_m1         = rd_len - 10'd1;
   assign m_axi_ar_id    = AR_ID;
   assign m_axi_ar_addr  = ar_addr_q;
   assign m_axi_ar_len   = len_m1[7:0];
   assign m_axi_ar_size  = 3'b011;
   assign m_axi_ar_burst = 2'b01;
   assign m_axi_ar_lock  = 1'b0;
   assign m_axi_ar_cache = 4'b0010;
   assign m_axi_ar_prot  = 3'b000;
   assign m_axi_ar_qos   = 4'b0000;
   assign m_axi_ar_valid = ar_valid_q;

   assign m_axi_r_ready  = (state == RD_PROC);
   assign r_hs           = m_axi_r_valid & m_axi_r_ready;
   assign rd_fifo_we     = r_hs;
   assign rd_fifo_data   = m_axi_r_data;
   assign rd_ready       = (state == IDLE);
   assign rd_done        = (state == RD_DONE);

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state      <= IDLE;
         ar_addr_q  <= '0;
         ar_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state      <= state_nxt;
         ar_addr_q  <= ar_addr_nxt;
         ar_valid_q <= ar_valid_nxt;
         cnt_q      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ar_addr_nxt  = ar_addr_q;
      ar_valid_nxt = ar_valid_q;
      cnt_nxt      = cnt_q;
      case (state)
         IDLE: begin
            if (rd_start) begin
               ar_addr_nxt = rd_adrs;
               state_nxt   = RA_WAIT;
            end
         end
         RA_WAIT: state_nxt = RA_START;
         RA_START: begin
            ar_valid_nxt = 1'b1;
            state_nxt    = RA_HS;
         end
         RA_HS: begin
            if (ar_valid_q && m_axi_ar_ready) begin
               ar_valid_nxt = 1'b0;
               cnt_nxt      = len_m1[7:0];
               state_nxt    = RD_PROC;
            end
         end
         RD_PROC: begin
            // Either the slave's r_last or our own beat count closes the burst.
            if (r_hs) begin
               cnt_nxt = (cnt_q == '0) ? '0 : cnt_q - 8'd1;
               if (m_axi_r_last || (cnt_q == '0))
                  state_nxt = RD_DONE;
            end
         end
         RD_DONE: state_nxt = IDLE;
         default: begin
            state_nxt    = IDLE;
            ar_valid_nxt = 1'b0;
         end
      endcase
   end

`ifdef RD_ERR_CHECK_EN
   logic err_beat;

   assign err_beat = r_hs & ((m_axi_r_resp != 2'b00) | (m_axi_r_id != AR_ID) |
                             (m_axi_r_last != (cnt_q == '0)));

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n)
         rd_err <= 1'b0;
      else if (err_beat)
         rd_err <= 1'b1;
   end

   assign unused_ok = &{1'b0, len_m1[9:8]};
`else
   assign unused_ok = &{1'b0, m_axi_r_id, m_axi_r_resp, len_m1[9:8]};
`endif

endmodule

// File: tb/tb_axi_master_read.sv
// Scoreboard bench for axi_master_read: a randomized AXI slave feeds beats, a monitor checks FIFO writes,
// AR requests and rd_done against expectations queued at stimulus time. Define RD_ERR_CHECK_EN to test rd_err.
module tb_axi_master_read;

   logic        axi_clk = 1'b0;
   logic        axi_rst_n;
   logic [3:0]  m_axi_ar_id;
   logic [31:0] m_axi_ar_addr;
   logic [7:0]  m_axi_ar_len;
   logic [2:0]  m_axi_ar_size;
   logic [1:0]  m_axi_ar_burst;
   logic        m_axi_ar_lock;
   logic [3:0]  m_axi_ar_cache;
   logic [2:0]  m_axi_ar_prot;
   logic [3:0]  m_axi_ar_qos;
   logic        m_axi_ar_valid;
   logic        m_axi_ar_ready;
   logic [3:0]  m_axi_r_id;
   logic [63:0] m_axi_r_data;
   logic [1:0]  m_axi_r_resp;
   logic        m_axi_r_last;
   logic        m_axi_r_valid;
   logic        m_axi_r_ready;
   logic        rd_start;
   logic [31:0] rd_adrs;
   logic [9:0]  rd_len;
   logic        rd_ready;
   logic        rd_fifo_we;
   logic [63:0] rd_fifo_data;
   logic        rd_done;
`ifdef RD_ERR_CHECK_EN
   logic        rd_err;
`endif

   axi_master_read dut (
      .axi_clk        (axi_clk),
      .axi_rst_n      (axi_rst_n),
      .m_axi_ar_id    (m_axi_ar_id),
      .m_axi_ar_addr  (m_axi_ar_addr),
      .m_axi_ar_len   (m_axi_ar_len),
      .m_axi_ar_size  (m_axi_ar_size),
      .m_axi_ar_burst (m_axi_ar_burst),
      .m_axi_ar_lock  (m_axi_ar_lock),
      .m_axi_ar_cache (m_axi_ar_cache),
      .m_axi_ar_prot  (m_axi_ar_prot),
      .m_axi_ar_qos   (m_axi_ar_qos),
      .m_axi_ar_valid (m_axi_ar_valid),
      .m_axi_ar_ready (m_axi_ar_ready),
      .m_axi_r_id     (m_axi_r_id),
      .m_axi_r_data   (m_axi_r_data),
      .m_axi_r_resp   (m_axi_r_resp),
      .m_axi_r_last   (m_axi_r_last),
      .m_axi_r_valid  (m_axi_r_valid),
      .m_axi_r_ready  (m_axi_r_ready),
      .rd_start       (rd_start),
      .rd_adrs        (rd_adrs),
      .rd_len         (rd_len),
      .rd_ready       (rd_ready),
      .rd_fifo_we     (rd_fifo_we),
      .rd_fifo_data   (rd_fifo_data),
      .rd_done        (rd_done)
`ifdef RD_ERR_CHECK_EN
      ,
      .rd_err         (rd_err)
`endif
   );

   initial forever #5 axi_clk = ~axi_clk;

   // Scoreboard state
   logic [63:0] exp_data[$];
   logic [31:0] exp_ar_addr[$];
   logic [7:0]  exp_ar_len[$];
   int          exp_done;
   int          n_checks;
   int          n_fail;
   int          beats_seen;
   int          done_seen;
   int          done_target;

   // Slave knobs and state
   int          ar_delay;
   int          rv_pct;
   bit          err_inject;
   logic [31:0] sl_addr[$];
   int          sl_len[$];
   int          beat;
   int          ar_hold;
   bit          p_ar_valid;
   bit          p_r_ready;
   logic [31:0] p_ar_addr;
   logic [7:0]  p_ar_len;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // AXI slave: answers AR, then streams beats tagged with burst address and beat index.
   initial begin
      m_axi_ar_ready = 1'b0;
      m_axi_r_valid  = 1'b0;
      m_axi_r_data   = '0;
      m_axi_r_last   = 1'b0;
      m_axi_r_resp   = 2'b00;
      m_axi_r_id     = 4'hF;
      beat = 0; ar_hold = 0; p_ar_valid = 0; p_r_ready = 0;
      p_ar_addr = '0; p_ar_len = '0;
      forever begin
         @(posedge axi_clk); #1;
         if (!axi_rst_n) begin
            sl_addr.delete(); sl_len.delete();
            beat = 0; ar_hold = 0; p_ar_valid = 0; p_r_ready = 0;
            m_axi_ar_ready = 1'b0;
            m_axi_r_valid  = 1'b0;
            m_axi_r_last   = 1'b0;
            continue;
         end
         if (p_ar_valid && m_axi_ar_ready) begin
            check("ar_valid_hold_cycles", 64'(ar_hold), 64'(ar_delay));
            check("ar_id", 64'(m_axi_ar_id), 64'hF);
            check("ar_size", 64'(m_axi_ar_size), 64'h3);
            check("ar_burst", 64'(m_axi_ar_burst), 64'h1);
            if (exp_ar_addr.size() == 0)
               check("ar_unexpected_hs", 64'd1, 64'd0);
            else begin
               check("ar_addr", 64'(p_ar_addr), 64'(exp_ar_addr.pop_front()));
               check("ar_len", 64'(p_ar_len), 64'(exp_ar_len.pop_front()));
            end
            sl_addr.push_back(p_ar_addr);
            sl_len.push_back(int'(p_ar_len) + 1);
            ar_hold = 0;
         end else if (p_ar_valid) begin
            ar_hold++;
         end
         if (m_axi_ar_valid) begin
            if (exp_ar_addr.size() == 0)
               check("ar_valid_unexpected", 64'd1, 64'd0);
            else
               check("ar_addr_while_valid", 64'(m_axi_ar_addr), 64'(exp_ar_addr[0]));
         end
         if (m_axi_r_valid && p_r_ready && sl_len.size() > 0) begin
            beat++;
            if (beat == sl_len[0]) begin
               void'(sl_addr.pop_front());
               void'(sl_len.pop_front());
               beat = 0;
            end
         end
         m_axi_ar_ready = m_axi_ar_valid && (ar_hold >= ar_delay);
         if (sl_len.size() > 0 && $urandom_range(99, 0) < rv_pct) begin
            m_axi_r_valid = 1'b1;
            m_axi_r_data  = {sl_addr[0], 32'(beat)};
            m_axi_r_last  = (beat == sl_len[0] - 1);
            m_axi_r_resp  = (err_inject && beat == 2) ? 2'b10 : 2'b00;
         end else begin
            m_axi_r_valid = 1'b0;
            m_axi_r_data  = {$urandom, $urandom};
            m_axi_r_last  = 1'b0;
            m_axi_r_resp  = 2'b00;
         end
         p_ar_valid = m_axi_ar_valid;
         p_ar_addr  = m_axi_ar_addr;
         p_ar_len   = m_axi_ar_len;
         p_r_ready  = m_axi_r_ready;
      end
   end

   // Monitor: pops expectations whenever the DUT writes the FIFO or signals done.
   initial begin
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge axi_clk);
         if (!axi_rst_n) begin
            prev_done = 1'b0;
            continue;
         end
         if (rd_fifo_we) begin
            beats_seen++;
            if (exp_data.size() == 0)
               check("fifo_we_unexpected", 64'd1, 64'd0);
            else
               check("fifo_data", rd_fifo_data, exp_data.pop_front());
         end
         if (rd_done) begin
            check("rd_done_single_cycle", 64'(prev_done), 64'd0);
            check("rd_ready_low_in_done", 64'(rd_ready), 64'd0);
            check("beats_left_at_done", 64'(exp_data.size()), 64'd0);
            if (exp_done == 0)
               check("rd_done_unexpected", 64'd1, 64'd0);
            else
               exp_done--;
            done_seen++;
         end
         prev_done = rd_done;
      end
   end

   task automatic wait_idle();
      @(posedge axi_clk); #1;
      for (int i = 0; i < 300 && !rd_ready; i++) begin
         @(posedge axi_clk); #1;
      end
      check("idle_wait", 64'(rd_ready), 64'd1);
   endtask

   task automatic push_expect(input logic [31:0] addr, input int len);
      exp_ar_addr.push_back(addr);
      exp_ar_len.push_back(8'(len - 1));
      for (int i = 0; i < len; i++)
         exp_data.push_back({addr, 32'(i)});
      exp_done++;
      done_target = done_seen + 1;
   endtask

   task automatic start_burst(input logic [31:0] addr, input int len);
      wait_idle();
      push_expect(addr, len);
      rd_adrs  = addr;
      rd_len   = 10'(len);
      rd_start = 1'b1;
      @(posedge axi_clk); #1;
      rd_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 5000 && done_seen < done_target; i++)
         @(negedge axi_clk);
      check("rd_done_timeout", 64'(done_seen >= done_target), 64'd1);
      @(negedge axi_clk);
      check("rd_ready_after_done", 64'(rd_ready), 64'd1);
   endtask

   task automatic run_burst(input logic [31:0] addr, input int len);
      start_burst(addr, len);
      wait_done();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ar_valid"}, 64'(m_axi_ar_valid), 64'd0);
      check({tag, "_ar_addr"}, 64'(m_axi_ar_addr), 64'd0);
      check({tag, "_r_ready"}, 64'(m_axi_r_ready), 64'd0);
      check({tag, "_fifo_we"}, 64'(rd_fifo_we), 64'd0);
      check({tag, "_rd_done"}, 64'(rd_done), 64'd0);
      check({tag, "_rd_ready"}, 64'(rd_ready), 64'd1);
`ifdef RD_ERR_CHECK_EN
      check({tag, "_rd_err"}, 64'(rd_err), 64'd0);
`endif
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr;
      int          len, lat, b0;

      axi_rst_n = 1'b0;
      rd_start = 1'b0; rd_adrs = '0; rd_len = 10'd1;
      ar_delay = 0; rv_pct = 100; err_inject = 0;
      exp_done = 0; n_checks = 0; n_fail = 0;
      beats_seen = 0; done_seen = 0; done_target = 0;

      repeat (3) @(posedge axi_clk);
      #1;
      check_reset_values("reset");
      check("reset_ar_id", 64'(m_axi_ar_id), 64'hF);
      check("reset_ar_lock", 64'(m_axi_ar_lock), 64'd0);
      check("reset_ar_cache", 64'(m_axi_ar_cache), 64'h2);
      check("reset_ar_prot", 64'(m_axi_ar_prot), 64'd0);
      check("reset_ar_qos", 64'(m_axi_ar_qos), 64'd0);
      axi_rst_n = 1'b1;

      // Baseline 16-beat burst, immediate handshakes
      run_burst(32'h0000_1000, 16);

      // Minimum latency: 1 beat, immediate ready/valid
      wait_idle();
      push_expect(32'h0000_0040, 1);
      rd_adrs = 32'h0000_0040; rd_len = 10'd1; rd_start = 1'b1;
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge axi_clk); #1;
         rd_start = 1'b0;
         lat++;
         if (rd_done) break;
      end
      check("latency_1beat", 64'(lat), 64'd5);
      @(posedge axi_clk); #1;
      check("rd_done_cleared", 64'(rd_done), 64'd0);
      check("rd_ready_back", 64'(rd_ready), 64'd1);

      // Delayed AR ready, single beat
      ar_delay = 4;
      run_burst(32'h0000_2008, 1);
      ar_delay = 0;

      // Full 256-beat burst with random r_valid gaps
      rv_pct = 50;
      run_burst(32'h0001_0000, 256);

      // rd_start while busy must be ignored
      rv_pct = 100;
      start_burst(32'h0000_3000, 8);
      rd_adrs = 32'hDEAD_0000; rd_start = 1'b1;
      @(posedge axi_clk); #1;
      rd_start = 1'b0;
      wait_done();
      repeat (10) @(posedge axi_clk);

      // Randomized bursts
      for (int k = 0; k < 6; k++) begin
         addr = $urandom;
         addr[2:0] = 3'b000;
         len = (k == 0) ? 2 : (k == 1) ? 255 : int'($urandom_range(256, 1));
         ar_delay = int'($urandom_range(3, 0));
         rv_pct = int'($urandom_range(100, 30));
         run_burst(addr, len);
      end
      ar_delay = 0; rv_pct = 100;

      // Asynchronous reset mid-burst, then a clean burst
      start_burst(32'h0000_5000, 16);
      b0 = beats_seen;
      for (int i = 0; i < 300 && beats_seen < b0 + 5; i++)
         @(negedge axi_clk);
      check("beats_before_reset", 64'(beats_seen >= b0 + 5), 64'd1);
      #2;
      axi_rst_n = 1'b0;
      #1;
      check_reset_values("midburst_reset");
      exp_data.delete(); exp_ar_addr.delete(); exp_ar_len.delete(); exp_done = 0;
      repeat (3) @(posedge axi_clk);
      #2;
      axi_rst_n = 1'b1;
      run_burst(32'h0000_6000, 4);

`ifdef RD_ERR_CHECK_EN
      check("rd_err_clean_traffic", 64'(rd_err), 64'd0);
      err_inject = 1;
      run_burst(32'h0000_7000, 16);
      err_inject = 0;
      check("rd_err_set", 64'(rd_err), 64'd1);
      run_burst(32'h0000_7800, 3);
      check("rd_err_sticky", 64'(rd_err), 64'd1);
      @(negedge axi_clk);
      axi_rst_n = 1'b0;
      #1;
      check("rd_err_reset", 64'(rd_err), 64'd0);
      @(posedge axi_clk); #2;
      axi_rst_n = 1'b1;
`endif

      repeat (10) @(posedge axi_clk);
      #1;
      check("exp_data_empty", 64'(exp_data.size()), 64'd0);
      check("exp_ar_empty", 64'(exp_ar_addr.size()), 64'd0);
      check("exp_done_empty", 64'(exp_done), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
